lsu_wbuf: RTL

- Parametrised load/store unit placed between the riscv core's data interface (core_*) and the data memory port (mem_*).
- Successor to the single-access, always-stalling LSU. Adds a configurable data width (32/64), byte-lane steering generalised to DATA_W/8 lanes, and a posted-store write buffer of WBUF_DEPTH entries.
- Also adds a fence input and access-error reporting.
- Loads stay blocking and are ordered behind all buffered stores.

---
 rtl/lsu_wbuf.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lsu_wbuf.sv
// Load/store unit between the core data port and data memory, with a posted-store
// write buffer. Loads block and are ordered behind every buffered store.
module lsu_wbuf #(
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        core_req_i,
    input  logic                        core_we_i,
    input  logic [2:0]                  core_size_i,
    input  logic [31:0]                 core_addr_i,
    input  logic [DATA_W-1:0]           core_wd_i,
    output logic [DATA_W-1:0]           core_rd_o,
    output logic                        core_stall_o,
    input  logic                        fence_i,
    output logic                        err_o,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [DATA_W/8-1:0]         mem_be_o,
    output logic [31:0]                 mem_addr_o,
    output logic [DATA_W-1:0]           mem_wd_o,
    input  logic [DATA_W-1:0]           mem_rd_i,
    input  logic                        mem_ready_i
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(WBUF_DEPTH);
    localparam int CW   = PW + 1;

    function automatic logic [NB-1:0] lane_be(input logic [1:0] lg, input logic [OFFW-1:0] off);
        logic [NB-1:0] be;
        int lo, hi;
        lo = int'(off);
        hi = lo + (1 << lg);
        for (int i = 0; i < NB; i++) be[i] = (i >= lo) && (i < hi);
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd, input logic [1:0] lg);
        logic [DATA_W-1:0] r;
        int mask;
        mask = (1 << lg) - 1;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = wd[8*(i & mask) +: 8];
        return r;
    endfunction

    // Shift the addressed lane down, then sign- or zero-extend above the access width.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rd,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [2:0] size);
        logic [DATA_W-1:0] sh, r;
        logic ext;
        int nbits;
        sh    = rd >> {off, 3'b000};
        nbits = 8 << size[1:0];
        if (nbits > DATA_W) nbits = DATA_W;
        ext   = !size[2] && sh[nbits-1];
        for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? sh[i] : ext;
        return r;
    endfunction

    logic [1:0]      lg;
    logic [OFFW-1:0] off;
    logic [31:0]     aligned;
    logic            illegal, misal, err, st_req, ld_req;
    logic            nonempty, full, pop, push, load_go;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]       wb_addr_q [WBUF_DEPTH];
    logic [NB-1:0]     wb_be_q   [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_wd_q   [WBUF_DEPTH];

    assign lg      = core_size_i[1:0];
    assign off     = core_addr_i[OFFW-1:0];
    assign aligned = {core_addr_i[31:OFFW], {OFFW{1'b0}}};
    assign illegal = (core_size_i == 3'd7) ||
                     ((DATA_W == 32) && (core_size_i == 3'd3 || core_size_i == 3'd6));
    assign misal   = (core_addr_i[2:0] & ((3'd1 << lg) - 3'd1)) != 3'd0;
    assign err     = core_req_i && (illegal || misal);
    assign st_req  = core_req_i && core_we_i && !err;
    assign ld_req  = core_req_i && !core_we_i && !err;

    assign nonempty = count_q != '0;
    assign full     = count_q == CW'(WBUF_DEPTH);
    assign pop      = nonempty && mem_ready_i;
    // A full buffer still accepts a store in the cycle its head retires.
    assign push     = st_req && (!full || pop);
    assign load_go  = ld_req && !nonempty;

    assign head_d  = pop  ? head_q + PW'(1) : head_q;
    assign tail_d  = push ? tail_q + PW'(1) : tail_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign err_o        = err;
    assign wbuf_count_o = count_q;
    assign core_rd_o    = (load_go && mem_ready_i) ? extract(mem_rd_i, off, core_size_i) : '0;
    assign core_stall_o = !err && ((st_req && !push) ||
                                   (ld_req && (nonempty || !mem_ready_i)) ||
                                   (fence_i && nonempty));

    // Buffered stores own the memory port; a load is issued only once the buffer is empty.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        if (nonempty) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_be_o   = wb_be_q[head_q];
            mem_addr_o = wb_addr_q[head_q];
            mem_wd_o   = wb_wd_q[head_q];
        end else if (load_go) begin
            mem_req_o  = 1'b1;
            mem_be_o   = lane_be(lg, off);
            mem_addr_o = aligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            wb_addr_q[tail_q] <= aligned;
            wb_be_q[tail_q]   <= lane_be(lg, off);
            wb_wd_q[tail_q]   <= replicate(core_wd_i, lg);
        end
    end
endmodule
